fwd_hazard_ctrl: RTL

- Pipeline-control sequencer for the EX-stage operand bypass mux.
- Shadows the rd, regwrite and load flags of the EX and MEM stages.
- Computes registered per-operand bypass selects for the instruction entering EX.
- Detects load-use hazards and inserts one bubble; freezes the whole pipeline while a data-memory access in MEM is not ready.

---
 rtl/fwd_hazard_ctrl.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl: pipeline-control sequencer for the EX-stage operand bypass mux.
// Tracks the EX and MEM stage destinations, produces registered bypass selects
// for the instruction entering EX, inserts a single bubble on a load-use hazard
// and freezes the whole pipeline while the MEM-stage data access is not ready.
// Optional build macro FWD_HAZ_PERF_EN adds saturating performance counters
// (perf_ld_stall, perf_mem_wait, perf_fwd).
module fwd_hazard_ctrl #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_regwrite,
    input  logic              id_is_load,
    input  logic              id_mem_acc,
    input  logic              dmem_ready,
    output logic              stall_if_id,
    output logic              bubble_ex,
    output logic              freeze_all,
    output logic              alu_bypass_rs1,
    output logic              alu_bypass_rs2,
    output logic              dmem_bypass_rs1,
    output logic              dmem_bypass_rs2,
    output logic [1:0]        state_o
`ifdef FWD_HAZ_PERF_EN
    ,
    output logic [CNT_W-1:0]  perf_ld_stall,
    output logic [CNT_W-1:0]  perf_mem_wait,
    output logic [CNT_W-1:0]  perf_fwd
`endif
);

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_LD_STALL = 2'd1;
    localparam logic [1:0] ST_MEM_WAIT = 2'd2;

    localparam logic [REG_AW-1:0] REG_ZERO = {REG_AW{1'b0}};

    // EX / MEM stage shadows
    logic              ex_vld_r, ex_wr_r, ex_ld_r, ex_mem_r;
    logic [REG_AW-1:0] ex_rd_r;
    logic              mem_vld_r, mem_wr_r, mem_ld_r, mem_mem_r;
    logic [REG_AW-1:0] mem_rd_r;

    logic [1:0] state_r;
    logic       flush_pend_r;
    logic       alu_rs1_r, alu_rs2_r, dmem_rs1_r, dmem_rs2_r;

    logic       rd_rs1_s, rd_rs2_s;
    logic       hit_ex_rs1_s, hit_ex_rs2_s, hit_mem_rs1_s, hit_mem_rs2_s;
    logic       load_use_s;
    logic       alu_nxt_rs1_s, alu_nxt_rs2_s, dmem_nxt_rs1_s, dmem_nxt_rs2_s;
    logic       flush_eff_s, mem_wait_s;
    logic       freeze_s, bubble_s;
    logic [1:0] next_state_s;

    // Operand match against the EX and MEM producers and next bypass selects
    always_comb begin
        rd_rs1_s       = id_valid & id_use_rs1 & (id_rs1 != REG_ZERO);
        rd_rs2_s       = id_valid & id_use_rs2 & (id_rs2 != REG_ZERO);
        hit_ex_rs1_s   = rd_rs1_s & ex_vld_r & ex_wr_r & (ex_rd_r == id_rs1);
        hit_ex_rs2_s   = rd_rs2_s & ex_vld_r & ex_wr_r & (ex_rd_r == id_rs2);
        hit_mem_rs1_s  = rd_rs1_s & mem_vld_r & mem_wr_r & (mem_rd_r == id_rs1);
        hit_mem_rs2_s  = rd_rs2_s & mem_vld_r & mem_wr_r & (mem_rd_r == id_rs2);
        load_use_s     = (hit_ex_rs1_s | hit_ex_rs2_s) & ex_ld_r;
        // the younger (EX) producer wins over the older (MEM) one
        alu_nxt_rs1_s  = hit_ex_rs1_s & ~ex_ld_r;
        alu_nxt_rs2_s  = hit_ex_rs2_s & ~ex_ld_r;
        dmem_nxt_rs1_s = ~alu_nxt_rs1_s & hit_mem_rs1_s;
        dmem_nxt_rs2_s = ~alu_nxt_rs2_s & hit_mem_rs2_s;
    end

    // Control decision: reset, then MEM wait, then flush, then load-use
    always_comb begin
        flush_eff_s  = flush | flush_pend_r;
        mem_wait_s   = mem_vld_r & mem_mem_r & ~dmem_ready;
        freeze_s     = 1'b0;
        bubble_s     = 1'b0;
        next_state_s = ST_RUN;
        if (rst) begin
            next_state_s = ST_RUN;
        end else begin
            case (state_r)
                // the release cycle of a wait re-checks the hazard like RUN so a
                // load-use that was pending behind the freeze still stalls
                ST_RUN, ST_MEM_WAIT: begin
                    if (mem_wait_s) begin
                        freeze_s     = 1'b1;
                        next_state_s = ST_MEM_WAIT;
                    end else if (flush_eff_s) begin
                        next_state_s = ST_RUN;
                    end else if (load_use_s) begin
                        bubble_s     = 1'b1;
                        next_state_s = ST_LD_STALL;
                    end else begin
                        next_state_s = ST_RUN;
                    end
                end
                ST_LD_STALL: begin
                    if (mem_wait_s) begin
                        freeze_s     = 1'b1;
                        next_state_s = ST_MEM_WAIT;
                    end else begin
                        next_state_s = ST_RUN;
                    end
                end
                default: begin
                    next_state_s = ST_RUN;
                end
            endcase
        end
    end

    assign freeze_all      = freeze_s;
    assign bubble_ex       = bubble_s;
    assign stall_if_id     = freeze_s | bubble_s;
    assign alu_bypass_rs1  = alu_rs1_r;
    assign alu_bypass_rs2  = alu_rs2_r;
    assign dmem_bypass_rs1 = dmem_rs1_r;
    assign dmem_bypass_rs2 = dmem_rs2_r;
    assign state_o         = state_r;

    // Stage shadows: MEM <- EX and EX <- ID (or a bubble) on every advance edge
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_vld_r  <= 1'b0;
            ex_rd_r   <= REG_ZERO;
            ex_wr_r   <= 1'b0;
            ex_ld_r   <= 1'b0;
            ex_mem_r  <= 1'b0;
            mem_vld_r <= 1'b0;
            mem_rd_r  <= REG_ZERO;
            mem_wr_r  <= 1'b0;
            mem_ld_r  <= 1'b0;
            mem_mem_r <= 1'b0;
        end else if (!freeze_s) begin
            mem_vld_r <= ex_vld_r;
            mem_rd_r  <= ex_rd_r;
            mem_wr_r  <= ex_wr_r;
            mem_ld_r  <= ex_ld_r;
            mem_mem_r <= ex_mem_r;
            if (bubble_s || flush_eff_s) begin
                ex_vld_r <= 1'b0;
                ex_rd_r  <= REG_ZERO;
                ex_wr_r  <= 1'b0;
                ex_ld_r  <= 1'b0;
                ex_mem_r <= 1'b0;
            end else begin
                ex_vld_r <= id_valid;
                ex_rd_r  <= id_rd;
                ex_wr_r  <= id_regwrite;
                ex_ld_r  <= id_is_load;
                ex_mem_r <= id_mem_acc;
            end
        end
    end

    // Bypass selects follow the instruction into EX; cleared by a bubble or kill
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_rs1_r  <= 1'b0;
            alu_rs2_r  <= 1'b0;
            dmem_rs1_r <= 1'b0;
            dmem_rs2_r <= 1'b0;
        end else if (!freeze_s) begin
            if (bubble_s || flush_eff_s) begin
                alu_rs1_r  <= 1'b0;
                alu_rs2_r  <= 1'b0;
                dmem_rs1_r <= 1'b0;
                dmem_rs2_r <= 1'b0;
            end else begin
                alu_rs1_r  <= alu_nxt_rs1_s;
                alu_rs2_r  <= alu_nxt_rs2_s;
                dmem_rs1_r <= dmem_nxt_rs1_s;
                dmem_rs2_r <= dmem_nxt_rs2_s;
            end
        end
    end

    // FSM state register and a flush held over until the freeze releases
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_RUN;
            flush_pend_r <= 1'b0;
        end else begin
            state_r      <= next_state_s;
            flush_pend_r <= freeze_s ? (flush_pend_r | flush) : 1'b0;
        end
    end

`ifdef FWD_HAZ_PERF_EN
    logic [CNT_W-1:0] perf_ld_stall_r, perf_mem_wait_r, perf_fwd_r;
    logic             fwd_any_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            sat_inc = v;
        end else begin
            sat_inc = v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    assign fwd_any_s = ~freeze_s & ~bubble_s & ~flush_eff_s &
                       (alu_nxt_rs1_s | alu_nxt_rs2_s | dmem_nxt_rs1_s | dmem_nxt_rs2_s);

    // Saturating event counters for stalls, waits and forwarded operands
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_ld_stall_r <= {CNT_W{1'b0}};
            perf_mem_wait_r <= {CNT_W{1'b0}};
            perf_fwd_r      <= {CNT_W{1'b0}};
        end else begin
            if (state_r == ST_LD_STALL) perf_ld_stall_r <= sat_inc(perf_ld_stall_r);
            if (state_r == ST_MEM_WAIT) perf_mem_wait_r <= sat_inc(perf_mem_wait_r);
            if (fwd_any_s)              perf_fwd_r      <= sat_inc(perf_fwd_r);
        end
    end

    assign perf_ld_stall = perf_ld_stall_r;
    assign perf_mem_wait = perf_mem_wait_r;
    assign perf_fwd      = perf_fwd_r;
`else
    logic [31:0] unused_cnt_w_s;
    assign unused_cnt_w_s = CNT_W;
`endif

    logic unused_mem_ld_s;
    assign unused_mem_ld_s = mem_ld_r;

endmodule
